// File: rtl/mem_access_ctrl_if.sv
// Bundle of issue, ALU, data-memory and write-back signals around the LW/SW sequencer.
// master = the sequencer itself; slave = the surrounding datapath/memory.
interface mem_access_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        reg_write;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        done;
  logic [1:0]  err_code;

  modport master (
    input  instr_valid, instruction, rs_data, rt_data, alu_result, mem_ack, mem_rdata,
    output instr_ready, alu_a, alu_b, alu_control, mem_req, mem_we, mem_addr, mem_wdata,
           reg_write, reg_waddr, reg_wdata, done, err_code
  );

  modport slave (
    output instr_valid, instruction, rs_data, rt_data, alu_result, mem_ack, mem_rdata,
    input  instr_ready, alu_a, alu_b, alu_control, mem_req, mem_we, mem_addr, mem_wdata,
           reg_write, reg_waddr, reg_wdata, done, err_code
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// LW/SW sequencer: IDLE -> ADDR -> REQ -> FIN, with request timeout.
// Optional ALIGN_CHECK_EN: misaligned word address aborts with err_code 2'b11 before REQ.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input logic             clk,
  input logic             reset,
  mem_access_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, ADDR, REQ, FIN} state_e;

  localparam logic [5:0]      OP_LW  = 6'b100011;
  localparam logic [5:0]      OP_SW  = 6'b101011;
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [4:0]        rt_q, rt_d;
  logic [15:0]       imm_q, imm_d;
  logic [31:0]       rs_q, rs_d, rtv_q, rtv_d;
  logic [TO_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic              reg_write_q, reg_write_d, done_q, done_d;
  logic [4:0]        reg_waddr_q, reg_waddr_d;
  logic [31:0]       reg_wdata_q, reg_wdata_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              is_store, is_mem_op, misaligned;
  logic              unused_rs_field;

  assign unused_rs_field = ^bus.instruction[25:21];
  assign is_store  = (op_q == OP_SW);
  assign is_mem_op = (bus.instruction[31:26] == OP_LW) || (bus.instruction[31:26] == OP_SW);
  assign cnt_inc   = cnt_q + TO_W'(1);

`ifdef ALIGN_CHECK_EN
  assign misaligned = |bus.alu_result[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rt_d        = rt_q;
    imm_d       = imm_q;
    rs_d        = rs_q;
    rtv_d       = rtv_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    reg_write_d = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    done_d      = 1'b0;
    err_code_d  = err_code_q;
    case (state_q)
      IDLE: if (bus.instr_valid) begin
        op_d  = bus.instruction[31:26];
        rt_d  = bus.instruction[20:16];
        imm_d = bus.instruction[15:0];
        rs_d  = bus.rs_data;
        rtv_d = bus.rt_data;
        if (is_mem_op) begin
          state_d = ADDR;
        end else begin
          state_d     = FIN;
          done_d      = 1'b1;
          err_code_d  = 2'b01;
          reg_waddr_d = bus.instruction[20:16];
        end
      end
      ADDR: begin
        mem_addr_d  = bus.alu_result;
        mem_wdata_d = rtv_q;
        mem_we_d    = is_store;
        cnt_d       = '0;
        reg_waddr_d = rt_q;
        if (misaligned) begin
          state_d    = FIN;
          done_d     = 1'b1;
          err_code_d = 2'b11;
        end else begin
          state_d   = REQ;
          mem_req_d = 1'b1;
        end
      end
      REQ: begin
        // An ack on the final permitted cycle still completes normally.
        if (bus.mem_ack) begin
          state_d     = FIN;
          mem_req_d   = 1'b0;
          cnt_d       = '0;
          reg_wdata_d = bus.mem_rdata;
          reg_write_d = !is_store && (rt_q != 5'd0);
          done_d      = 1'b1;
          err_code_d  = 2'b00;
        end else if (cnt_inc == TO_LIM) begin
          state_d    = FIN;
          mem_req_d  = 1'b0;
          cnt_d      = '0;
          done_d     = 1'b1;
          err_code_d = 2'b10;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      rt_q        <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rtv_q       <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      reg_write_q <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      done_q      <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rt_q        <= rt_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rtv_q       <= rtv_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      reg_write_q <= reg_write_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      done_q      <= done_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.alu_a       = rs_q;
  assign bus.alu_b       = {{16{imm_q[15]}}, imm_q};
  assign bus.alu_control = (state_q == ADDR) ? 3'b010 : 3'b000;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.reg_write   = reg_write_q;
  assign bus.reg_waddr   = reg_waddr_q;
  assign bus.reg_wdata   = reg_wdata_q;
  assign bus.done        = done_q;
  assign bus.err_code    = err_code_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed cases, random LW/SW/illegal traffic,
// randomized memory latency and a mid-request reset.
module tb_mem_access_ctrl;
  localparam int TIMEOUT = 16;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  logic clk = 1'b0;
  logic reset;
  logic resp_ack = 1'b0;
  logic man_ack  = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_ctrl_if ifc();
  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (.clk(clk), .reset(reset), .bus(ifc));

  // Behavioural ALU: adds only when asked to.
  assign ifc.alu_result = (ifc.alu_control == 3'b010) ? ifc.alu_a + ifc.alu_b : (ifc.alu_a & ifc.alu_b);
  assign ifc.mem_ack    = resp_ack | man_ack;

  typedef struct {
    logic [1:0]  err;
    logic        rw;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        acc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    int          nreq;
    int          lat;
  } exp_t;
  typedef struct {
    int          delay;
    logic [31:0] rdata;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=1 expected=0", name);
  endtask

  // Memory side: serves each request from the plan queue; stray acks outside requests.
  initial begin : responder
    bit    busy = 1'b0;
    int    wcnt = 0;
    plan_t cur;
    cur.delay = 1000;
    cur.rdata = '0;
    ifc.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      resp_ack      = 1'b0;
      ifc.mem_rdata = $urandom;
      if (reset) begin
        busy = 1'b0;
      end else if (ifc.mem_req) begin
        if (!busy) begin
          busy = 1'b1;
          wcnt = 0;
          if (plan_q.size() > 0) cur = plan_q.pop_front();
          else begin cur.delay = 1000; cur.rdata = '0; end
        end
        if (wcnt == cur.delay) begin
          resp_ack      = 1'b1;
          ifc.mem_rdata = cur.rdata;
        end
        wcnt++;
      end else begin
        busy     = 1'b0;
        resp_ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  initial begin : monitor
    int   req_cnt = 0;
    int   acc_cyc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        req_cnt = 0;
        continue;
      end
      if (ifc.instr_valid && ifc.instr_ready) acc_cyc = cyc;
      if (ifc.mem_req) begin
        if (exp_q.size() == 0 || !exp_q[0].acc) flag("unexpected_mem_req");
        else begin
          chk("mem_addr",  ifc.mem_addr, exp_q[0].addr);
          chk("mem_we",    32'(ifc.mem_we), 32'(exp_q[0].we));
          if (exp_q[0].we) chk("mem_wdata", ifc.mem_wdata, exp_q[0].wd);
        end
        req_cnt++;
      end
      if (ifc.done) begin
        if (exp_q.size() == 0) flag("unexpected_done");
        else begin
          e = exp_q.pop_front();
          chk("err_code",  32'(ifc.err_code), 32'(e.err));
          chk("reg_write", 32'(ifc.reg_write), 32'(e.rw));
          if (e.rw) begin
            chk("reg_waddr", 32'(ifc.reg_waddr), 32'(e.waddr));
            chk("reg_wdata", ifc.reg_wdata, e.wdata);
          end
          chk("req_cycles", req_cnt, e.nreq);
          chk("latency",    cyc - acc_cyc, e.lat);
        end
        req_cnt = 0;
      end else if (ifc.reg_write) flag("reg_write_without_done");
    end
  end

  // Builds the expected outcome from the instruction rules, then presents it.
  task automatic issue(input logic [5:0] op, input logic [31:0] rs, input logic [15:0] imm,
                       input logic [4:0] rt, input logic [31:0] rtd, input int delay,
                       input logic [31:0] rdata);
    exp_t        e;
    plan_t       p;
    logic [31:0] addr;
    int          t;
    addr    = rs + {{16{imm[15]}}, imm};
    e       = '{default: 0};
    e.addr  = addr;
    e.we    = (op == OP_SW);
    e.wd    = rtd;
    e.waddr = rt;
    if (op != OP_LW && op != OP_SW) begin
      e.err = 2'b01;
      e.lat = 1;
    end
`ifdef ALIGN_CHECK_EN
    else if (addr[1:0] != 2'b00) begin
      e.err = 2'b11;
      e.lat = 2;
    end
`endif
    else begin
      e.acc = 1'b1;
      if (delay < TIMEOUT) begin
        e.nreq  = delay + 1;
        e.rw    = (op == OP_LW) && (rt != 5'd0);
        e.wdata = rdata;
      end else begin
        e.nreq = TIMEOUT;
        e.err  = 2'b10;
      end
      e.lat   = 2 + e.nreq;
      p.delay = delay;
      p.rdata = rdata;
      plan_q.push_back(p);
    end
    exp_q.push_back(e);
    ifc.instruction = {op, 5'($urandom), rt, imm};
    ifc.rs_data     = rs;
    ifc.rt_data     = rtd;
    ifc.instr_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!ifc.instr_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ifc.instr_ready) flag("instr_ready_timeout");
    @(posedge clk);
    #1;
    ifc.instr_valid = 1'b0;
    ifc.instruction = $urandom;
    ifc.rs_data     = $urandom;
    ifc.rt_data     = $urandom;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},   32'(ifc.mem_req), 0);
    chk({tag, "_mem_we"},    32'(ifc.mem_we), 0);
    chk({tag, "_mem_addr"},  ifc.mem_addr, 0);
    chk({tag, "_mem_wdata"}, ifc.mem_wdata, 0);
    chk({tag, "_reg_write"}, 32'(ifc.reg_write), 0);
    chk({tag, "_reg_waddr"}, 32'(ifc.reg_waddr), 0);
    chk({tag, "_reg_wdata"}, ifc.reg_wdata, 0);
    chk({tag, "_done"},      32'(ifc.done), 0);
    chk({tag, "_err_code"},  32'(ifc.err_code), 0);
    chk({tag, "_ready"},     32'(ifc.instr_ready), 1);
  endtask

  initial begin : stimulus
    int t;
    logic [5:0] op;
    reset           = 1'b1;
    ifc.instr_valid = 1'b0;
    ifc.instruction = '0;
    ifc.rs_data     = '0;
    ifc.rt_data     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases
    issue(OP_SW, 32'h100, 16'h0008, 5'd7, 32'hDEADBEEF, 0, 32'h0);
    issue(OP_LW, 32'h200, 16'hFFFC, 5'd5, 32'h0, 3, 32'h12345678);
    issue(OP_LW, 32'h300, 16'h0010, 5'd9, 32'h0, TIMEOUT + 1, 32'h0);
    issue(OP_LW, 32'h400, 16'h0004, 5'd0, 32'h0, 1, 32'hCAFEF00D);
    issue(6'b000000, 32'h500, 16'h0000, 5'd3, 32'h0, 0, 32'h0);
    issue(OP_SW, 32'h100, 16'h0002, 5'd4, 32'h55AA55AA, 0, 32'h0);
    issue(OP_LW, 32'h600, 16'h0000, 5'd1, 32'h0, TIMEOUT - 1, 32'hA5A5A5A5);
    issue(OP_LW, 32'hFFFF_FFFC, 16'h0008, 5'd2, 32'h0, 0, 32'h0BADCAFE);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    op = OP_LW;
        2, 3:    op = OP_SW;
        default: op = 6'($urandom);
      endcase
      issue(op,
            ($urandom_range(0, 5) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC),
            ($urandom_range(0, 5) == 0) ? 16'($urandom) : (16'($urandom) & 16'hFFFC),
            5'($urandom), $urandom,
            ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 1) : $urandom_range(0, 4),
            $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Reset while a store request is outstanding and never acked
    issue(OP_SW, 32'h700, 16'h0010, 5'd6, 32'hFEEDFACE, TIMEOUT + 1, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_mem_req", 32'(ifc.mem_req), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    plan_q.delete();
    chk_all_zero("midreset");
    reset   = 1'b0;
    man_ack = 1'b1;
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_reset_done",      32'(ifc.done), 0);
      chk("post_reset_reg_write", 32'(ifc.reg_write), 0);
      chk("post_reset_mem_req",   32'(ifc.mem_req), 0);
    end
    @(posedge clk);
    #1;
    issue(OP_LW, 32'h800, 16'h0020, 5'd12, 32'h0, 2, 32'h87654321);

    t = 0;
    while (exp_q.size() > 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() > 0) flag("drain_timeout");
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
